alu_issue_arbiter: RTL and testbench
====================================

Name: alu_issue_arbiter

Overview:
- Shares the single CPU ALU between two requesters: req0 (main pipeline) and req1 (auxiliary/debug issue port).
- Arbitrates between them round-robin and decodes each request's funct/ALUOp into the 3-bit ALU control code.
- Drives the ALU control and operand-select lines.
- Single-cycle ops (ADD/SUB/AND/OR) complete in 1 cycle; MUL holds the ALU for MUL_LAT cycles. Completion is reported per requester.

Parameters:
- MUL_LAT, 4, number of cycles the ALU is occupied by a MUL; legal range 2..15.
- CNT_W, 4, width of the MUL occupancy counter; must satisfy 2^CNT_W > MUL_LAT.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-low reset
- req0_valid_i  input  1  requester 0 has an operation pending
- req0_funct_i  input  6  requester 0 funct field
- req0_aluop_i  input  2  requester 0 ALUOp
- req0_ready_o  output  1  requester 0 accepted this cycle (valid&&ready = handshake)
- req1_valid_i  input  1  requester 1 has an operation pending
- req1_funct_i  input  6  requester 1 funct field
- req1_aluop_i  input  2  requester 1 ALUOp
- req1_ready_o  output  1  requester 1 accepted this cycle
- alu_ctrl_o  output  3  ALU operation code to ALU
- alu_en_o  output  1  ALU executing an issued op this cycle
- alu_src_sel_o  output  1  operand/result mux select: 0 = req0, 1 = req1
- done_valid_o  output  1  one-cycle pulse: issued op result valid on ALU output
- done_id_o  output  1  requester owning the completing op
- busy_o  output  1  high while in BUSY_MUL

Behaviour:
- Reset (rst_i low, async):
  - state = IDLE; rr_last = 1, so req0 wins the first contention.
  - alu_ctrl_o=0, alu_en_o=0, alu_src_sel_o=0, done_valid_o=0, done_id_o=0, busy_o=0; counter=0.
  - Asserting reset mid-MUL aborts the op; no done pulse is ever produced for it.
- Decode (combinational, per requester):
  - ALUOp 00: funct 100000→ADD=0, 100010→SUB=1, 011000→MUL=2, 100100→AND=3, 100101→OR=4, any other funct→0.
  - ALUOp 01→ADD=0.
  - ALUOp 10/11→0.
  - An op is_mul only when it decodes to code 2.
- Arbitration (IDLE only):
  - ready is combinational from valid.
  - One requester valid → that requester's ready=1.
  - Both valid → grant the requester != rr_last.
  - rr_last updates to the granted id on every handshake.
  - In BUSY_MUL both ready_o are 0.
  - A requester must hold valid, funct and aluop stable until its handshake.
- Issue, registered: on the handshake edge E0:
  - alu_ctrl_o <= decoded code
  - alu_src_sel_o <= grant id
  - alu_en_o <= 1
- Non-MUL op:
  - In cycle E0+1, done_valid_o=1 and done_id_o=grant id; state stays IDLE.
  - A new handshake in that same cycle is legal, so back-to-back ops issue every cycle.
  - With no handshake, alu_en_o and done_valid_o return to 0 next cycle; alu_ctrl_o and alu_src_sel_o hold their last value.
- MUL op:
  - At E0, state→BUSY_MUL and counter <= MUL_LAT-1.
  - Cycles E0+1 .. E0+MUL_LAT: alu_en_o=1, alu_ctrl_o=2, alu_src_sel_o fixed, busy_o=1.
  - Counter decrements each cycle.
  - In the cycle where counter==0, i.e. cycle E0+MUL_LAT, done_valid_o=1 with done_id_o; state→IDLE at the following edge.
  - Earliest next handshake is cycle E0+MUL_LAT+1.
- Requests arriving or dropping during BUSY_MUL are ignored (not granted, not lost); they are served after return to IDLE.
- done_valid_o is never high for two requesters in one cycle; exactly one done pulse per handshake.
- alu_en_o is never high without a preceding handshake.

Decomposition:
- Shared package alu_pkg:
  - ALU code constants ALU_ADD=0, ALU_SUB=1, ALU_MUL=2, ALU_AND=3, ALU_OR=4.
  - funct constants F_ADD/F_SUB/F_MUL/F_AND/F_OR.
  - ALUOp constants.
  - State enum {IDLE, BUSY_MUL}.
  - Decode function alu_decode(funct, aluop).
- One natural sub-module: alu_rr_pick2, a two-input round-robin picker producing grant id and ready vector from valids and rr_last.
- Counter and FSM stay in the top module.

Test Plan:
- Reset → all outputs 0.
  - req0 ADD: funct 100000, ALUOp 00, held 1 cycle.
  - Response: ready0 same cycle; next cycle alu_ctrl_o=0, alu_en_o=1, done_valid_o=1, done_id_o=0.
- req1 MUL: funct 011000, ALUOp 00, MUL_LAT=4.
  - Response: busy_o high for 4 cycles with alu_ctrl_o=2 and alu_src_sel_o=1; done pulse only in cycle 4 with done_id_o=1; ready0/ready1=0 throughout.
- Both valid continuously: req0 SUB (100010), req1 OR (100101).
  - Response: grants alternate 0,1,0,1; alu_ctrl_o alternates 1,4; one done per cycle.
- req0 MUL, then req1 AND (100100) asserted during BUSY_MUL.
  - Response: req1 granted in the first IDLE cycle after the MUL done; alu_ctrl_o=3.
- Decode corners, each with a done pulse:
  - ALUOp 01 with funct 011000 → code 0, single-cycle.
  - ALUOp 00 with funct 111111 → code 0.
  - ALUOp 10 → code 0.
- rst_i pulled low in cycle 2 of a MUL:
  - Outputs go to 0 asynchronously; no done pulse.
  - After release, req0 is granted first on contention.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings, FSM state type and the funct/ALUOp decoder used by the
// ALU issue arbiter.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_MUL = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_MUL = 6'b011000;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;

  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_MEM   = 2'b01;

  typedef enum logic {IDLE, BUSY_MUL} state_e;

  // Unknown funct values and the branch/immediate ALUOps fall back to ADD.
  function automatic logic [2:0] alu_decode(input logic [5:0] funct,
                                            input logic [1:0] aluop);
    logic [2:0] code;
    code = ALU_ADD;
    case (aluop)
      ALUOP_RTYPE: begin
        case (funct)
          F_ADD:   code = ALU_ADD;
          F_SUB:   code = ALU_SUB;
          F_MUL:   code = ALU_MUL;
          F_AND:   code = ALU_AND;
          F_OR:    code = ALU_OR;
          default: code = ALU_ADD;
        endcase
      end
      ALUOP_MEM: code = ALU_ADD;
      default:   code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// Request/issue bundle between the two requesters, the arbiter and the ALU.
interface alu_issue_arbiter_if;
  logic       req0_valid_i;
  logic [5:0] req0_funct_i;
  logic [1:0] req0_aluop_i;
  logic       req0_ready_o;
  logic       req1_valid_i;
  logic [5:0] req1_funct_i;
  logic [1:0] req1_aluop_i;
  logic       req1_ready_o;
  logic [2:0] alu_ctrl_o;
  logic       alu_en_o;
  logic       alu_src_sel_o;
  logic       done_valid_o;
  logic       done_id_o;
  logic       busy_o;

  modport slave (
    input  req0_valid_i, req0_funct_i, req0_aluop_i,
    input  req1_valid_i, req1_funct_i, req1_aluop_i,
    output req0_ready_o, req1_ready_o,
    output alu_ctrl_o, alu_en_o, alu_src_sel_o,
    output done_valid_o, done_id_o, busy_o
  );

  modport master (
    output req0_valid_i, req0_funct_i, req0_aluop_i,
    output req1_valid_i, req1_funct_i, req1_aluop_i,
    input  req0_ready_o, req1_ready_o,
    input  alu_ctrl_o, alu_en_o, alu_src_sel_o,
    input  done_valid_o, done_id_o, busy_o
  );
endinterface

// File: rtl/alu_rr_pick2.sv
// Two-input round-robin picker: on contention the requester that did not win
// last time is granted; ready is only raised when the picker is enabled.
module alu_rr_pick2 (
  input  logic [1:0] valid,
  input  logic       rr_last,
  input  logic       en,
  output logic [1:0] ready,
  output logic       gnt_id
);

  always_comb begin
    gnt_id = 1'b0;
    if (valid == 2'b11) begin
      gnt_id = ~rr_last;
    end else if (valid[1]) begin
      gnt_id = 1'b1;
    end
    ready = 2'b00;
    if (en && valid[gnt_id]) begin
      ready[gnt_id] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one ALU between two requesters: round-robin issue, funct/ALUOp decode,
// multi-cycle MUL occupancy and per-requester completion pulses.
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  alu_issue_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_last_q, rr_last_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             en_q, en_d;
  logic             src_q, src_d;
  logic             dv_q, dv_d;
  logic             did_q, did_d;

  logic [2:0] code0, code1, code_sel;
  logic [1:0] ready;
  logic       gnt_id;
  logic       idle;
  logic       hs;

  assign code0    = alu_decode(bus.req0_funct_i, bus.req0_aluop_i);
  assign code1    = alu_decode(bus.req1_funct_i, bus.req1_aluop_i);
  assign idle     = (state_q == IDLE);
  assign code_sel = gnt_id ? code1 : code0;
  assign hs       = |ready;

  alu_rr_pick2 u_pick (
    .valid   ({bus.req1_valid_i, bus.req0_valid_i}),
    .rr_last (rr_last_q),
    .en      (idle),
    .ready   (ready),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;
    ctrl_d    = ctrl_q;
    en_d      = 1'b0;
    src_d     = src_q;
    dv_d      = 1'b0;
    did_d     = did_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          rr_last_d = gnt_id;
          ctrl_d    = code_sel;
          src_d     = gnt_id;
          did_d     = gnt_id;
          en_d      = 1'b1;
          if (code_sel == ALU_MUL) begin
            state_d = BUSY_MUL;
            cnt_d   = CNT_INIT;
          end else begin
            dv_d = 1'b1;
          end
        end
      end
      BUSY_MUL: begin
        // Done is registered one cycle ahead so it lands in the counter==0 cycle.
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          en_d  = 1'b1;
          dv_d  = (cnt_q == CNT_ONE);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_last_q <= 1'b1;
      ctrl_q    <= ALU_ADD;
      en_q      <= 1'b0;
      src_q     <= 1'b0;
      dv_q      <= 1'b0;
      did_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      ctrl_q    <= ctrl_d;
      en_q      <= en_d;
      src_q     <= src_d;
      dv_q      <= dv_d;
      did_q     <= did_d;
    end
  end

  assign bus.req0_ready_o  = ready[0];
  assign bus.req1_ready_o  = ready[1];
  assign bus.alu_ctrl_o    = ctrl_q;
  assign bus.alu_en_o      = en_q;
  assign bus.alu_src_sel_o = src_q;
  assign bus.done_valid_o  = dv_q;
  assign bus.done_id_o     = did_q;
  assign bus.busy_o        = (state_q == BUSY_MUL);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with MUL_LAT=4.
module tb_alu_issue_arbiter;
  import alu_pkg::*;

  logic clk_i;
  logic rst_i;
  int   checks;
  int   passes;

  alu_issue_arbiter_if ifc ();

  alu_issue_arbiter #(.MUL_LAT(4), .CNT_W(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (ifc)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [5:0] f, input logic [1:0] op);
    ifc.req0_valid_i = v;
    ifc.req0_funct_i = f;
    ifc.req0_aluop_i = op;
  endtask

  task automatic set_req1(input logic v, input logic [5:0] f, input logic [1:0] op);
    ifc.req1_valid_i = v;
    ifc.req1_funct_i = f;
    ifc.req1_aluop_i = op;
  endtask

  task automatic test_reset;
    checks++;
    if ({ifc.alu_ctrl_o, ifc.alu_en_o, ifc.alu_src_sel_o, ifc.done_valid_o,
         ifc.done_id_o, ifc.busy_o} !== 8'd0)
      $display("FAIL reset_outputs got ctrl=%0d en=%b src=%b dv=%b id=%b busy=%b want all 0",
               ifc.alu_ctrl_o, ifc.alu_en_o, ifc.alu_src_sel_o, ifc.done_valid_o,
               ifc.done_id_o, ifc.busy_o);
    else passes++;
    rst_i = 1'b1;
    step();
    checks++;
    if ({ifc.alu_en_o, ifc.done_valid_o, ifc.busy_o, ifc.req0_ready_o, ifc.req1_ready_o} !== 5'd0)
      $display("FAIL post_reset_idle got en=%b dv=%b busy=%b r0=%b r1=%b want 0",
               ifc.alu_en_o, ifc.done_valid_o, ifc.busy_o, ifc.req0_ready_o, ifc.req1_ready_o);
    else passes++;
  endtask

  task automatic test_add;
    set_req0(1'b1, F_ADD, 2'b00);
    #1;
    checks++;
    if ({ifc.req1_ready_o, ifc.req0_ready_o} !== 2'b01)
      $display("FAIL add_ready got r1r0=%b want 01", {ifc.req1_ready_o, ifc.req0_ready_o});
    else passes++;
    step();
    set_req0(1'b0, F_ADD, 2'b00);
    checks++;
    if ({ifc.alu_ctrl_o, ifc.alu_en_o, ifc.alu_src_sel_o, ifc.done_valid_o, ifc.done_id_o} !==
        {3'd0, 1'b1, 1'b0, 1'b1, 1'b0})
      $display("FAIL add_issue got ctrl=%0d en=%b src=%b dv=%b id=%b want 0 1 0 1 0",
               ifc.alu_ctrl_o, ifc.alu_en_o, ifc.alu_src_sel_o, ifc.done_valid_o, ifc.done_id_o);
    else passes++;
    step();
    checks++;
    if ({ifc.alu_en_o, ifc.done_valid_o, ifc.busy_o} !== 3'b000)
      $display("FAIL add_quiet got en=%b dv=%b busy=%b want 000",
               ifc.alu_en_o, ifc.done_valid_o, ifc.busy_o);
    else passes++;
  endtask

  task automatic test_mul;
    set_req1(1'b1, F_MUL, 2'b00);
    #1;
    checks++;
    if ({ifc.req1_ready_o, ifc.req0_ready_o} !== 2'b10)
      $display("FAIL mul_ready got r1r0=%b want 10", {ifc.req1_ready_o, ifc.req0_ready_o});
    else passes++;
    step();
    set_req1(1'b0, F_MUL, 2'b00);
    set_req0(1'b1, F_ADD, 2'b00);
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++;
      if ({ifc.busy_o, ifc.alu_en_o, ifc.alu_ctrl_o, ifc.alu_src_sel_o} !== {1'b1, 1'b1, 3'd2, 1'b1})
        $display("FAIL mul_busy_c%0d got busy=%b en=%b ctrl=%0d src=%b want 1 1 2 1", i,
                 ifc.busy_o, ifc.alu_en_o, ifc.alu_ctrl_o, ifc.alu_src_sel_o);
      else passes++;
      checks++;
      if ({ifc.req1_ready_o, ifc.req0_ready_o} !== 2'b00)
        $display("FAIL mul_noready_c%0d got r1r0=%b want 00", i, {ifc.req1_ready_o, ifc.req0_ready_o});
      else passes++;
      checks++;
      if (ifc.done_valid_o !== (i == 4))
        $display("FAIL mul_done_c%0d got dv=%b want %b", i, ifc.done_valid_o, (i == 4));
      else passes++;
      if (i == 4) begin
        checks++;
        if (ifc.done_id_o !== 1'b1)
          $display("FAIL mul_done_id got %b want 1", ifc.done_id_o);
        else passes++;
        set_req0(1'b0, F_ADD, 2'b00);
      end
      step();
    end
    checks++;
    if ({ifc.busy_o, ifc.alu_en_o, ifc.done_valid_o} !== 3'b000)
      $display("FAIL mul_exit got busy=%b en=%b dv=%b want 000",
               ifc.busy_o, ifc.alu_en_o, ifc.done_valid_o);
    else passes++;
  endtask

  task automatic test_back_to_back;
    logic g;
    set_req0(1'b1, F_SUB, 2'b00);
    set_req1(1'b1, F_OR, 2'b00);
    for (int i = 0; i < 4; i++) begin
      g = (i % 2 == 1);
      #1;
      checks++;
      if ({ifc.req1_ready_o, ifc.req0_ready_o} !== (g ? 2'b10 : 2'b01))
        $display("FAIL b2b_grant_%0d got r1r0=%b want %b", i,
                 {ifc.req1_ready_o, ifc.req0_ready_o}, (g ? 2'b10 : 2'b01));
      else passes++;
      step();
      checks++;
      if ({ifc.alu_ctrl_o, ifc.alu_src_sel_o, ifc.alu_en_o, ifc.done_valid_o, ifc.done_id_o} !==
          {(g ? 3'd4 : 3'd1), g, 1'b1, 1'b1, g})
        $display("FAIL b2b_issue_%0d got ctrl=%0d src=%b en=%b dv=%b id=%b want ctrl=%0d id=%b", i,
                 ifc.alu_ctrl_o, ifc.alu_src_sel_o, ifc.alu_en_o, ifc.done_valid_o,
                 ifc.done_id_o, (g ? 3'd4 : 3'd1), g);
      else passes++;
    end
    set_req0(1'b0, F_SUB, 2'b00);
    set_req1(1'b0, F_OR, 2'b00);
    step();
    checks++;
    if ({ifc.alu_en_o, ifc.done_valid_o, ifc.alu_ctrl_o} !== {1'b0, 1'b0, 3'd4})
      $display("FAIL b2b_hold got en=%b dv=%b ctrl=%0d want 0 0 4",
               ifc.alu_en_o, ifc.done_valid_o, ifc.alu_ctrl_o);
    else passes++;
  endtask

  task automatic test_mul_then_and;
    set_req0(1'b1, F_MUL, 2'b00);
    #1;
    checks++;
    if (ifc.req0_ready_o !== 1'b1)
      $display("FAIL mul0_ready got %b want 1", ifc.req0_ready_o);
    else passes++;
    step();
    set_req0(1'b0, F_MUL, 2'b00);
    set_req1(1'b1, F_AND, 2'b00);
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++;
      if ({ifc.busy_o, ifc.req1_ready_o, ifc.done_valid_o} !== {1'b1, 1'b0, (i == 4)})
        $display("FAIL mul0_wait_c%0d got busy=%b r1=%b dv=%b want 1 0 %b", i,
                 ifc.busy_o, ifc.req1_ready_o, ifc.done_valid_o, (i == 4));
      else passes++;
      if (i == 4) begin
        checks++;
        if ({ifc.done_id_o, ifc.alu_src_sel_o} !== 2'b00)
          $display("FAIL mul0_done_id got id=%b src=%b want 0 0", ifc.done_id_o, ifc.alu_src_sel_o);
        else passes++;
      end
      step();
    end
    checks++;
    if ({ifc.busy_o, ifc.req1_ready_o} !== 2'b01)
      $display("FAIL and_ready got busy=%b r1=%b want 0 1", ifc.busy_o, ifc.req1_ready_o);
    else passes++;
    step();
    set_req1(1'b0, F_AND, 2'b00);
    checks++;
    if ({ifc.alu_ctrl_o, ifc.alu_src_sel_o, ifc.done_valid_o, ifc.done_id_o} !== {3'd3, 1'b1, 1'b1, 1'b1})
      $display("FAIL and_issue got ctrl=%0d src=%b dv=%b id=%b want 3 1 1 1",
               ifc.alu_ctrl_o, ifc.alu_src_sel_o, ifc.done_valid_o, ifc.done_id_o);
    else passes++;
    step();
  endtask

  task automatic test_decode;
    logic [5:0] fv [4];
    logic [1:0] ov [4];
    fv = '{6'b011000, 6'b111111, 6'b100010, 6'b011000};
    ov = '{2'b01, 2'b00, 2'b10, 2'b11};
    for (int i = 0; i < 4; i++) begin
      set_req0(1'b1, F_OR, 2'b00);
      step();
      set_req0(1'b1, fv[i], ov[i]);
      step();
      set_req0(1'b0, fv[i], ov[i]);
      checks++;
      if ({ifc.alu_ctrl_o, ifc.alu_en_o, ifc.done_valid_o, ifc.done_id_o, ifc.busy_o} !==
          {3'd0, 1'b1, 1'b1, 1'b0, 1'b0})
        $display("FAIL decode_%0d got ctrl=%0d en=%b dv=%b id=%b busy=%b want 0 1 1 0 0", i,
                 ifc.alu_ctrl_o, ifc.alu_en_o, ifc.done_valid_o, ifc.done_id_o, ifc.busy_o);
      else passes++;
      step();
      checks++;
      if ({ifc.busy_o, ifc.done_valid_o} !== 2'b00)
        $display("FAIL decode_%0d_after got busy=%b dv=%b want 00", i, ifc.busy_o, ifc.done_valid_o);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_mul;
    set_req0(1'b1, F_MUL, 2'b00);
    step();
    set_req0(1'b0, F_MUL, 2'b00);
    step();
    checks++;
    if (ifc.busy_o !== 1'b1)
      $display("FAIL rmul_busy got %b want 1", ifc.busy_o);
    else passes++;
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({ifc.alu_ctrl_o, ifc.alu_en_o, ifc.alu_src_sel_o, ifc.done_valid_o,
         ifc.done_id_o, ifc.busy_o} !== 8'd0)
      $display("FAIL rmul_async got ctrl=%0d en=%b src=%b dv=%b id=%b busy=%b want all 0",
               ifc.alu_ctrl_o, ifc.alu_en_o, ifc.alu_src_sel_o, ifc.done_valid_o,
               ifc.done_id_o, ifc.busy_o);
    else passes++;
    step();
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({ifc.done_valid_o, ifc.busy_o, ifc.alu_en_o} !== 3'b000)
        $display("FAIL rmul_nodone_%0d got dv=%b busy=%b en=%b want 000", i,
                 ifc.done_valid_o, ifc.busy_o, ifc.alu_en_o);
      else passes++;
    end
    set_req0(1'b1, F_SUB, 2'b00);
    set_req1(1'b1, F_OR, 2'b00);
    #1;
    checks++;
    if ({ifc.req1_ready_o, ifc.req0_ready_o} !== 2'b01)
      $display("FAIL rmul_first_grant got r1r0=%b want 01", {ifc.req1_ready_o, ifc.req0_ready_o});
    else passes++;
    step();
    set_req0(1'b0, F_SUB, 2'b00);
    set_req1(1'b0, F_OR, 2'b00);
    checks++;
    if ({ifc.alu_ctrl_o, ifc.alu_src_sel_o, ifc.done_valid_o, ifc.done_id_o} !== {3'd1, 1'b0, 1'b1, 1'b0})
      $display("FAIL rmul_first_issue got ctrl=%0d src=%b dv=%b id=%b want 1 0 1 0",
               ifc.alu_ctrl_o, ifc.alu_src_sel_o, ifc.done_valid_o, ifc.done_id_o);
    else passes++;
    step();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_i  = 1'b0;
    set_req0(1'b0, 6'd0, 2'b00);
    set_req1(1'b0, 6'd0, 2'b00);
    step();
    step();
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_mul_then_and();
    test_decode();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
